// File: rtl/cpu_bus_responder_if.sv
// CPU-side, external-side and OAM signals of the 6502 bus responder.
interface cpu_bus_responder_if;
    logic [15:0] i_address;
    logic        i_rw;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        o_rdy;
    logic        o_ext_en;
    logic [15:0] o_ext_address;
    logic        o_ext_rw;
    logic [7:0]  o_ext_data;
    logic [7:0]  i_ext_data;
    logic        o_oam_we;
    logic [7:0]  o_oam_addr;
    logic [7:0]  o_oam_data;

    modport slave (
        input  i_address, i_rw, i_data, i_ext_data,
        output o_data, o_rdy, o_ext_en, o_ext_address,
        output o_ext_rw, o_ext_data,
        output o_oam_we, o_oam_addr, o_oam_data
    );

    modport master (
        output i_address, i_rw, i_data, i_ext_data,
        input  o_data, o_rdy, o_ext_en, o_ext_address,
        input  o_ext_rw, o_ext_data,
        input  o_oam_we, o_oam_addr, o_oam_data
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// Work RAM, external bus forwarding and $4014 sprite DMA
// for the 6502 core.
module cpu_bus_responder #(
    parameter int          RAM_ADDR_BITS = 11,
    parameter logic [15:0] DMA_REG       = 16'h4014
) (
    input logic i_clk,
    input logic i_reset,
    cpu_bus_responder_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ALIGN2 = 3'd1;
    localparam logic [2:0] ALIGN1 = 3'd2;
    localparam logic [2:0] READ   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;

    logic [7:0] mem [1 << RAM_ADDR_BITS];

    logic [2:0]  state;
    logic        parity;
    logic [7:0]  page;
    logic [7:0]  index;
    logic [7:0]  latch;
    logic [7:0]  data_q;

    logic        idle;
    logic        cpu_ram;
    logic        dma_hit;
    logic        cpu_ext;
    logic [15:0] src;
    logic        dma_rd;
    logic        dma_ram;
    logic        dma_ext;
    logic        ram_we;
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic [7:0]  ram_rd;

    assign idle    = (state == IDLE);
    assign cpu_ram = idle && (bus.i_address[15:13] == 3'b000);
    assign dma_hit = idle && !bus.i_rw && (bus.i_address == DMA_REG);
    assign cpu_ext = idle && !cpu_ram && !dma_hit;
    assign src     = {page, index};
    assign dma_rd  = (state == READ);
    assign dma_ram = dma_rd && (src[15:13] == 3'b000);
    assign dma_ext = dma_rd && !dma_ram;

    // Dropping the upper address bits is what mirrors RAM.
    assign ram_idx = dma_rd ? src[RAM_ADDR_BITS-1:0]
                            : bus.i_address[RAM_ADDR_BITS-1:0];
    assign ram_rd  = mem[ram_idx];
    assign ram_we  = cpu_ram && !bus.i_rw && !i_reset;

    always_ff @(posedge i_clk) begin
        if (ram_we) mem[ram_idx] <= bus.i_data;
    end

    always_comb begin
        bus.o_ext_en      = 1'b0;
        bus.o_ext_address = 16'h0000;
        bus.o_ext_rw      = 1'b1;
        bus.o_ext_data    = 8'h00;
        if (!i_reset) begin
            unique case (1'b1)
                cpu_ext: begin
                    bus.o_ext_en      = 1'b1;
                    bus.o_ext_address = bus.i_address;
                    bus.o_ext_rw      = bus.i_rw;
                    bus.o_ext_data    = bus.i_data;
                end
                dma_ext: begin
                    bus.o_ext_en      = 1'b1;
                    bus.o_ext_address = src;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            parity <= 1'b0;
            page   <= 8'h00;
            index  <= 8'h00;
            latch  <= 8'h00;
            data_q <= 8'h00;
        end else begin
            parity <= ~parity;
            unique case (state)
                IDLE: begin
                    if (bus.i_rw) begin
                        unique case (1'b1)
                            cpu_ram: data_q <= ram_rd;
                            cpu_ext: data_q <= bus.i_ext_data;
                            default: ;
                        endcase
                    end
                    if (dma_hit) begin
                        page  <= bus.i_data;
                        index <= 8'h00;
                        state <= parity ? ALIGN2 : ALIGN1;
                    end
                end
                ALIGN2: state <= ALIGN1;
                ALIGN1: state <= READ;
                READ: begin
                    latch <= dma_ram ? ram_rd : bus.i_ext_data;
                    state <= WRITE;
                end
                WRITE: begin
                    index <= index + 8'd1;
                    state <= (index == 8'hFF) ? IDLE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_rdy      = idle;
    assign bus.o_oam_we   = (state == WRITE);
    assign bus.o_oam_addr = index;
    assign bus.o_oam_data = latch;
endmodule
